// File: rtl/bsg_demux_bitwise_buffered.sv
// Bitwise demux: splits each accepted word into two buffered channel halves under a per-bit mask,
// each tagged with a wrapping sequence number. Define BSG_DEMUX_BITWISE_EMIT_EMPTY_EN to always load both halves.
module bsg_demux_bitwise_buffered #(
  parameter int unsigned width_p     = 64,
  parameter int unsigned tag_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  input  logic [width_p-1:0]     sel_i,
  output logic                   ready_o,
  output logic                   v0_o,
  output logic [width_p-1:0]     data0_o,
  output logic [width_p-1:0]     mask0_o,
  output logic [tag_width_p-1:0] tag0_o,
  input  logic                   yumi0_i,
  output logic                   v1_o,
  output logic [width_p-1:0]     data1_o,
  output logic [width_p-1:0]     mask1_o,
  output logic [tag_width_p-1:0] tag1_o,
  input  logic                   yumi1_i
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  chan_state_e state0_r, state0_n, state1_r, state1_n;
  logic [tag_width_p-1:0] tag_r;
  logic need0, need1, free0, free1, accept, load0, load1;

  // Which halves this word must occupy; a skipped half never blocks the input.
  always_comb begin
`ifdef BSG_DEMUX_BITWISE_EMIT_EMPTY_EN
    need0 = 1'b1;
    need1 = 1'b1;
`else
    need0 = |(~sel_i);
    need1 = |sel_i;
`endif
    free0   = (state0_r == EMPTY) | yumi0_i;
    free1   = (state1_r == EMPTY) | yumi1_i;
    ready_o = (~need0 | free0) & (~need1 | free1);
    accept  = v_i & ready_o;
    load0   = accept & need0;
    load1   = accept & need1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state0_r <= EMPTY;
      state1_r <= EMPTY;
    end else begin
      state0_r <= state0_n;
      state1_r <= state1_n;
    end
  end

  // A same-cycle load wins over yumi so a full channel streams back-to-back.
  always_comb begin
    state0_n = state0_r;
    state1_n = state1_r;
    if (load0)        state0_n = FULL;
    else if (yumi0_i) state0_n = EMPTY;
    if (load1)        state1_n = FULL;
    else if (yumi1_i) state1_n = EMPTY;
  end

  assign v0_o = (state0_r == FULL);
  assign v1_o = (state1_r == FULL);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_r   <= '0;
      data0_o <= '0;
      mask0_o <= '0;
      tag0_o  <= '0;
      data1_o <= '0;
      mask1_o <= '0;
      tag1_o  <= '0;
    end else begin
      if (accept) tag_r <= tag_r + tag_width_p'(1);
      if (load0) begin
        data0_o <= data_i & ~sel_i;
        mask0_o <= ~sel_i;
        tag0_o  <= tag_r;
      end
      if (load1) begin
        data1_o <= data_i & sel_i;
        mask1_o <= sel_i;
        tag1_o  <= tag_r;
      end
    end
  end

  // Consuming an empty channel is a protocol violation by the downstream logic.
  a_yumi0_legal: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi0_i && !v0_o));
  a_yumi1_legal: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi1_i && !v1_o));

endmodule

// File: doc/bsg_demux_bitwise_buffered.md
Name: bsg_demux_bitwise_buffered

Overview:
Inverse of the per-bit 2:1 select datapath. It splits each incoming word into two output streams, channel 0 and channel 1, under a per-bit steering mask. Downstream, the two halves can be re-merged by a bitwise mux keyed on the same mask. Each channel has a one-entry output register with a valid/yumi handshake. The input side uses valid/ready. Every accepted word carries a wrapping sequence tag so the receiver can re-pair the halves.

Parameters:
width_p, 64, data/steering width in bits
tag_width_p, 4, width of the per-word sequence tag; wraps modulo 2^tag_width_p

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
v_i  in  1  input word valid
data_i  in  width_p  input word
sel_i  in  width_p  steering mask; bit=1 routes that bit to channel 1, bit=0 routes it to channel 0
ready_o  out  1  block can accept the input word this cycle
v0_o  out  1  channel 0 output valid
data0_o  out  width_p  data_i & ~sel_i of the held word
mask0_o  out  width_p  ~sel_i of the held word
tag0_o  out  tag_width_p  sequence tag of the held word
yumi0_i  in  1  channel 0 consumed this cycle; legal only while v0_o=1
v1_o  out  1  channel 1 output valid
data1_o  out  width_p  data_i & sel_i of the held word
mask1_o  out  width_p  sel_i of the held word
tag1_o  out  tag_width_p  sequence tag of the held word
yumi1_i  in  1  channel 1 consumed this cycle; legal only while v1_o=1

Behaviour:
- Reset (asynchronous assert, released on clk_i edge):
  - v0_o=v1_o=0; data/mask/tag registers=0; tag counter=0.
  - Words held at reset are discarded; reset in mid-operation loses them silently.
- Per-channel state: EMPTY / FULL (the valid bit).
  - EMPTY->FULL on a load.
  - FULL->EMPTY on yumi without a load.
  - FULL stays FULL on yumi plus a same-cycle load (back-to-back).
- Need flags:
  - need0 = |(~sel_i); need1 = |sel_i.
  - An all-zeros mask needs only channel 0; an all-ones mask needs only channel 1.
- Channel free: free_c = ~v_c | yumi_c.
- ready_o = (~need0 | free0) & (~need1 | free1).
  - Combinational from sel_i and yumi*_i; no path from v_i.
- Accept = v_i & ready_o.
  - On accept, each channel with need_c=1 loads data/mask/tag at the next edge.
  - A channel with need_c=0 is untouched; if FULL it stays FULL unless yumi'd.
- Latency: a word accepted in cycle N is visible on outputs in cycle N+1.
- Throughput: 1 word/cycle when consumers yumi every cycle.
- Tag:
  - The tag counter increments by 1 on each accept, wrapping 2^tag_width_p-1 -> 0.
  - Both halves of one word carry the identical tag.
- Channels drain independently. Channel 0 may hold tag k+1 while channel 1 still holds tag k from an earlier word.
- Reconstruction invariant: for the same tag, (data1 & mask1) | (data0 & mask0) == original data_i, and mask0 == ~mask1 when both halves exist.
- Error handling: yumi_c while v_c=0 is illegal. It triggers a simulation assertion error; the hardware ignores it.

Optional Feature:
BSG_DEMUX_BITWISE_EMIT_EMPTY_EN
- Defined: need0=need1=1 for every word, so both channels always load, even an all-zero half.
  - The receiver then sees strictly paired tags.
  - ready_o = free0 & free1.
- Undefined: a channel whose half-mask is all zeros is skipped, per the need rules above.

Test Plan:
- Reset mid-stream: assert reset_i while both channels are FULL -> v0_o=v1_o=0 immediately; after release the first accepted word has tag 0.
- Split: data_i=64'hDEAD_BEEF_0123_4567, sel_i=64'hFFFF_0000_FFFF_0000, v_i=1 -> next cycle data1_o=64'hDEAD_0000_0123_0000, data0_o=64'h0000_BEEF_0000_4567, mask1_o=sel_i, tags equal 0.
- Skip: sel_i=0 -> only v0_o rises, v1_o stays 0.
  - With EMIT_EMPTY_EN defined: v1_o=1 with data1_o=0 and mask1_o=0.
- Backpressure: channel 1 FULL and yumi1_i=0, new word with need1=1 -> ready_o=0, no load.
  - Same cycle with yumi1_i=1 -> ready_o=1, the word loads, v1_o stays 1 with the new tag.
- Independent drain: channel 1 stalled for 3 cycles while sel_i=0 words stream -> channel 0 accepts tags 1,2,3 back-to-back; channel 1 keeps tag 0.
- Wrap and random: 2^tag_width_p+3 accepts -> tag sequence 0..15,0,1,2.
  - Randomised yumi with a scoreboard re-merging halves by tag -> every word reconstructs exactly.
